// File: rtl/draw_sprite_anim.sv
// Overlays one animated, scalable, mirrorable sprite on the VGA stream.
// Position and visibility are latched at each vblank edge so a frame never tears.
module draw_sprite_anim #(
    parameter int          WIDTH        = 48,
    parameter int          HEIGHT       = 64,
    parameter int          ADDR_WIDTH_X = 6,
    parameter int          ADDR_WIDTH_Y = 6,
    parameter int          FRAMES       = 4,
    parameter int          FRAME_BITS   = 2,
    parameter int          FRAME_DIV    = 8,
    parameter int          SCALE_X_BITS = 0,
    parameter int          SCALE_Y_BITS = 0,
    parameter int          ROM_LATENCY  = 1,
    parameter int          TRANSPARENCY = 1,
    parameter logic [11:0] ALPHA        = 12'h000
) (
    input  logic                                       pclk,
    input  logic                                       rst_n,
    input  logic [10:0]                                hcount_in,
    input  logic [10:0]                                vcount_in,
    input  logic                                       hsync_in,
    input  logic                                       vsync_in,
    input  logic                                       hblnk_in,
    input  logic                                       vblnk_in,
    input  logic [11:0]                                rgb_in,
    output logic [10:0]                                hcount_out,
    output logic [10:0]                                vcount_out,
    output logic                                       hsync_out,
    output logic                                       vsync_out,
    output logic                                       hblnk_out,
    output logic                                       vblnk_out,
    output logic [11:0]                                rgb_out,
    output logic                                       hit_out,
    output logic [FRAME_BITS+ADDR_WIDTH_Y+ADDR_WIDTH_X-1:0] pixel_addr,
    input  logic [11:0]                                rgb_pixel,
    input  logic [10:0]                                xpos,
    input  logic [10:0]                                ypos,
    input  logic                                       invert,
    input  logic                                       enable,
    input  logic                                       anim_run
);

    localparam int          L        = 1 + ROM_LATENCY;
    localparam int          DIV_BITS = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [12:0] SPAN_X   = 13'(WIDTH << SCALE_X_BITS);
    localparam logic [12:0] SPAN_Y   = 13'(HEIGHT << SCALE_Y_BITS);

    typedef struct packed {
        logic [10:0] hc;
        logic [10:0] vc;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic [11:0] rgb;
        logic        hit;
    } vid_t;

    logic                    vblnk_prev;
    logic [10:0]             xpos_s;
    logic [10:0]             ypos_s;
    logic                    invert_s;
    logic                    enable_s;
    logic [FRAME_BITS-1:0]   frame;
    logic [DIV_BITS-1:0]     divider;
    vid_t                    pipe [L];

    // Window compare is done 13 bits wide so a sprite hanging past 2047 clips instead of wrapping.
    logic [12:0]             hc13, vc13, x_lo, x_hi, y_lo, y_hi, dx, dy, col_raw, row_raw;
    logic [ADDR_WIDTH_X-1:0] col_n, col_s;
    logic [ADDR_WIDTH_Y-1:0] row_s;
    logic                    hit_c;
    logic                    vblank_edge;
    logic                    opaque;
    vid_t                    cur;
    vid_t                    last;

    assign hc13    = {2'b00, hcount_in};
    assign vc13    = {2'b00, vcount_in};
    assign x_lo    = {2'b00, xpos_s};
    assign y_lo    = {2'b00, ypos_s};
    assign x_hi    = x_lo + SPAN_X;
    assign y_hi    = y_lo + SPAN_Y;
    assign dx      = hc13 - x_lo;
    assign dy      = vc13 - y_lo;
    assign col_raw = dx >> SCALE_X_BITS;
    assign row_raw = dy >> SCALE_Y_BITS;
    assign col_n   = ADDR_WIDTH_X'(col_raw);
    assign col_s   = invert_s ? (ADDR_WIDTH_X'(WIDTH - 1) - col_n) : col_n;
    assign row_s   = ADDR_WIDTH_Y'(row_raw);

    assign hit_c = enable_s && !hblnk_in && !vblnk_in &&
                   (hc13 >= x_lo) && (hc13 < x_hi) &&
                   (vc13 >= y_lo) && (vc13 < y_hi);

    assign vblank_edge = vblnk_in && !vblnk_prev;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vblnk_prev <= 1'b0;
            xpos_s     <= '0;
            ypos_s     <= '0;
            invert_s   <= 1'b0;
            enable_s   <= 1'b0;
            frame      <= '0;
            divider    <= '0;
        end else begin
            vblnk_prev <= vblnk_in;
            if (vblank_edge) begin
                xpos_s   <= xpos;
                ypos_s   <= ypos;
                invert_s <= invert;
                enable_s <= enable;
                if (anim_run) begin
                    if (divider == DIV_BITS'(FRAME_DIV - 1)) begin
                        divider <= '0;
                        frame   <= (frame == FRAME_BITS'(FRAMES - 1)) ? '0 : frame + 1'b1;
                    end else begin
                        divider <= divider + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_addr <= '0;
        end else if (hit_c) begin
            pixel_addr <= {frame, row_s, col_s};
        end
    end

    assign cur = '{hc: hcount_in, vc: vcount_in, hs: hsync_in, vs: vsync_in,
                   hb: hblnk_in, vb: vblnk_in, rgb: rgb_in, hit: hit_c};

    // L stages so the timing lands on the same cycle as the ROM data for this pixel.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < L; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= cur;
            for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign last   = pipe[L-1];
    assign opaque = !((TRANSPARENCY != 0) && (rgb_pixel == ALPHA));

    assign hcount_out = last.hc;
    assign vcount_out = last.vc;
    assign hsync_out  = last.hs;
    assign vsync_out  = last.vs;
    assign hblnk_out  = last.hb;
    assign vblnk_out  = last.vb;
    assign hit_out    = last.hit && opaque;
    assign rgb_out    = hit_out ? rgb_pixel : last.rgb;

endmodule

// File: tb/tb_draw_sprite_anim.sv
// Scoreboard bench for draw_sprite_anim: 2-cycle ROM, 2x horizontal scale, 2 video frames per step.
module tb_draw_sprite_anim;

    localparam int L = 3;

    logic        pclk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] hcount_in = '0, vcount_in = '0;
    logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
    logic [11:0] rgb_in = '0;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;
    logic        hit_out;
    logic [13:0] pixel_addr;
    logic [11:0] rgb_pixel;
    logic [10:0] xpos = '0, ypos = '0;
    logic        invert = 1'b0, enable = 1'b0, anim_run = 1'b0;

    draw_sprite_anim #(
        .WIDTH(48), .HEIGHT(64), .ADDR_WIDTH_X(6), .ADDR_WIDTH_Y(6),
        .FRAMES(4), .FRAME_BITS(2), .FRAME_DIV(2),
        .SCALE_X_BITS(1), .SCALE_Y_BITS(0), .ROM_LATENCY(2),
        .TRANSPARENCY(1), .ALPHA(12'h000)
    ) dut (
        .pclk(pclk), .rst_n(rst_n),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out), .hit_out(hit_out), .pixel_addr(pixel_addr), .rgb_pixel(rgb_pixel),
        .xpos(xpos), .ypos(ypos), .invert(invert), .enable(enable), .anim_run(anim_run)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    // ROM contents: {1, frame, row[2:0], col}; column 5 is the transparent key.
    function automatic logic [11:0] rom_val(input int f, input int row, input int col);
        if (col == 5) return 12'h000;
        return {1'b1, 2'(f), 3'(row), 6'(col)};
    endfunction

    logic [11:0] rom_p0 = '0, rom_p1 = '0;
    always @(posedge pclk) begin
        rom_p0 <= rom_val(int'(pixel_addr[13:12]), int'(pixel_addr[11:6]), int'(pixel_addr[5:0]));
        rom_p1 <= rom_p0;
    end
    assign rgb_pixel = rom_p1;

    typedef struct {
        int          due;
        logic [10:0] hc;
        logic [10:0] vc;
        logic [3:0]  tim;
        logic [11:0] rgb;
        logic        hit;
    } exp_t;
    exp_t exp_q[$];

    int n_vec = 0;
    int n_bad = 0;

    int m_x = 0, m_y = 0, m_inv = 0, m_en = 0, m_frame = 0, m_div = 0;
    logic m_prev_vb = 1'b0;

    task automatic model_reset();
        m_x = 0; m_y = 0; m_inv = 0; m_en = 0; m_frame = 0; m_div = 0; m_prev_vb = 1'b0;
    endtask

    task automatic pix(input int h, input int v, input logic hb, input logic vb);
        exp_t e;
        int col;
        logic [11:0] p;
        hcount_in = 11'(h);
        vcount_in = 11'(v);
        hsync_in  = (h % 5 == 0);
        vsync_in  = (v % 3 == 0);
        hblnk_in  = hb;
        vblnk_in  = vb;
        rgb_in    = 12'(h * 13 + v * 7 + 1);
        e.due = cyc + L;
        e.hc  = hcount_in;
        e.vc  = vcount_in;
        e.tim = {hsync_in, vsync_in, hb, vb};
        e.rgb = rgb_in;
        e.hit = 1'b0;
        if (m_en != 0 && !hb && !vb && h >= m_x && h < m_x + 96 && v >= m_y && v < m_y + 64) begin
            col = (h - m_x) / 2;
            if (m_inv != 0) col = 47 - col;
            p = rom_val(m_frame, v - m_y, col);
            if (p != 12'h000) begin
                e.rgb = p;
                e.hit = 1'b1;
            end
        end
        exp_q.push_back(e);
        if (vb && !m_prev_vb) begin
            m_x = int'(xpos); m_y = int'(ypos); m_inv = int'(invert); m_en = int'(enable);
            if (anim_run) begin
                if (m_div == 1) begin
                    m_div = 0;
                    m_frame = (m_frame == 3) ? 0 : m_frame + 1;
                end else begin
                    m_div = m_div + 1;
                end
            end
        end
        m_prev_vb = vb;
        @(posedge pclk);
        #1;
    endtask

    task automatic vbl();
        pix(10, 600, 1'b0, 1'b0);
        pix(11, 600, 1'b0, 1'b1);
        pix(12, 600, 1'b0, 1'b1);
        pix(13, 601, 1'b0, 1'b0);
    endtask

    task automatic check_zero(input string name);
        logic [64:0] all;
        all = {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
               rgb_out, hit_out, pixel_addr, 11'd0};
        n_vec++;
        if (all != '0) begin
            n_bad++;
            $display("FAIL %s: outputs=%h required 0", name, all);
        end
    endtask

    always @(negedge pclk) begin
        if (rst_n && exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            n_vec++;
            if (e.due != cyc || hcount_out !== e.hc || vcount_out !== e.vc ||
                {hsync_out, vsync_out, hblnk_out, vblnk_out} !== e.tim ||
                rgb_out !== e.rgb || hit_out !== e.hit) begin
                n_bad++;
                $display("FAIL pixel h=%0d v=%0d: got hc=%0d vc=%0d tim=%b rgb=%h hit=%b, required hc=%0d vc=%0d tim=%b rgb=%h hit=%b (due %0d at %0d)",
                         e.hc, e.vc, hcount_out, vcount_out,
                         {hsync_out, vsync_out, hblnk_out, vblnk_out}, rgb_out, hit_out,
                         e.hc, e.vc, e.tim, e.rgb, e.hit, e.due, cyc);
            end
        end
    end

    initial begin
        int budget;
        xpos = 11'd100; ypos = 11'd50; invert = 1'b0; enable = 1'b1; anim_run = 1'b1;
        repeat (3) @(posedge pclk);
        #1;
        check_zero("reset_outputs");
        rst_n = 1'b1;

        // Nothing latched yet: sprite stays invisible.
        for (int h = 95; h <= 110; h++) pix(h, 50, 1'b0, 1'b0);

        // Alignment, window edges, alpha on column 5, position held across mid-frame change.
        vbl();
        for (int h = 96; h <= 200; h++) pix(h, 50, 1'b0, 1'b0);
        xpos = 11'd500;
        for (int h = 96; h <= 200; h++) pix(h, 113, 1'b0, 1'b0);
        for (int h = 190; h <= 200; h++) pix(h, 114, 1'b0, 1'b0);
        for (int h = 98; h <= 102; h++) pix(h, 49, 1'b0, 1'b0);
        pix(120, 60, 1'b1, 1'b0);
        pix(121, 60, 1'b0, 1'b0);

        // Mirror with 2x scale.
        xpos = 11'd200; invert = 1'b1;
        vbl();
        for (int h = 196; h <= 300; h++) pix(h, 60, 1'b0, 1'b0);

        // Animation steps, then hold.
        xpos = 11'd0; ypos = 11'd0; invert = 1'b0;
        for (int k = 0; k < 9; k++) begin
            vbl();
            pix(0, 0, 1'b0, 1'b0);
            pix(2, 1, 1'b0, 1'b0);
        end
        anim_run = 1'b0;
        for (int k = 0; k < 5; k++) begin
            vbl();
            pix(0, 0, 1'b0, 1'b0);
        end
        anim_run = 1'b1;
        vbl();
        vbl();
        pix(0, 0, 1'b0, 1'b0);

        // Clip at the right edge of the coordinate space.
        xpos = 11'd2040; ypos = 11'd10;
        vbl();
        for (int h = 2030; h <= 2047; h++) pix(h, 10, 1'b0, 1'b0);
        for (int h = 0; h <= 5; h++) pix(h, 10, 1'b0, 1'b0);

        // Reset mid-line while sprite pixels are in flight.
        xpos = 11'd100; ypos = 11'd50; enable = 1'b1;
        vbl();
        for (int h = 100; h <= 104; h++) pix(h, 50, 1'b0, 1'b0);
        rst_n = 1'b0;
        exp_q.delete();
        model_reset();
        #1;
        check_zero("reset_mid_line");
        @(posedge pclk);
        #1;
        check_zero("reset_held");
        rst_n = 1'b1;
        for (int h = 100; h <= 110; h++) pix(h, 50, 1'b0, 1'b0);

        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            @(posedge pclk);
            budget++;
        end
        if (exp_q.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d pending, required 0", exp_q.size());
        end
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
